// File: rtl/card_pkg.sv
// Shared types and default geometry for the memory-game card renderer.
// Used by the card renderer, its symbol generator and the board-level preview.
package card_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHRINK  = 2'd1,
    ST_EXPAND  = 2'd2,
    ST_MATCHED = 2'd3
  } card_state_t;

  localparam logic [2:0] SYM_PLUS   = 3'd0;
  localparam logic [2:0] SYM_MINUS  = 3'd1;
  localparam logic [2:0] SYM_CROSS  = 3'd2;
  localparam logic [2:0] SYM_CIRCLE = 3'd3;
  localparam logic [2:0] SYM_HASH   = 3'd4;
  localparam logic [2:0] SYM_SQUARE = 3'd5;
  localparam logic [2:0] SYM_TRI_UP = 3'd6;
  localparam logic [2:0] SYM_TRI_DN = 3'd7;

  localparam int unsigned COORD_W         = 10;
  localparam int unsigned DEF_CARD_W      = 50;
  localparam int unsigned DEF_CARD_H      = 70;
  localparam int unsigned DEF_SYM_SIZE    = 30;
  localparam int unsigned DEF_SYM_T       = 4;
  localparam int unsigned DEF_FLIP_FRAMES = 5;

endpackage

// File: rtl/card_symbol_gen.sv
// Combinational symbol rasteriser: reports whether (x, y) lies on the selected
// symbol drawn in a SYM_SIZE box centred on (cx, cy).
module card_symbol_gen
  import card_pkg::*;
#(
  parameter int unsigned SYM_SIZE = DEF_SYM_SIZE,
  parameter int unsigned SYM_T    = DEF_SYM_T
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  input  logic [2:0] symbol_sel,
  output logic       hit
);

  localparam int HS = int'(SYM_SIZE / 2);
  localparam int QS = int'(SYM_SIZE / 4);
  localparam int TS = int'(SYM_T);
  localparam int TL = TS / 2;

  localparam logic signed [11:0] H_S   = 12'(HS);
  localparam logic signed [11:0] HT_S  = 12'(HS - TS);
  localparam logic signed [11:0] T_S   = 12'(TS);
  localparam logic signed [11:0] BAR_L = 12'(-TL);
  localparam logic signed [11:0] BAR_R = 12'(TS - TL);
  localparam logic signed [11:0] Q_L   = 12'(QS - TL);
  localparam logic signed [11:0] Q_R   = 12'(QS + TS - TL);
  localparam logic [23:0]        R_OUT2 = 24'(HS * HS);
  localparam logic [23:0]        R_IN2  = 24'((HS - TS) * (HS - TS));

  logic signed [11:0] dx, dy, ax, ay, sum, dif, asum, adif;
  logic [23:0]        d2;
  logic inbox, vbar, hbar, diag, ring, hash_v, hash_h, frame, tri_up, tri_dn;

  // Offsets from the box centre and the primitive shape tests built on them.
  always_comb begin
    dx   = $signed({2'b00, x}) - $signed({2'b00, cx});
    dy   = $signed({2'b00, y}) - $signed({2'b00, cy});
    ax   = (dx < 12'sd0) ? -dx : dx;
    ay   = (dy < 12'sd0) ? -dy : dy;
    sum  = dx + dy;
    dif  = dx - dy;
    asum = (sum < 12'sd0) ? -sum : sum;
    adif = (dif < 12'sd0) ? -dif : dif;
    d2   = 24'($unsigned(ax)) * 24'($unsigned(ax)) + 24'($unsigned(ay)) * 24'($unsigned(ay));

    inbox  = (ax <= H_S) && (ay <= H_S);
    vbar   = (dx >= BAR_L) && (dx < BAR_R);
    hbar   = (dy >= BAR_L) && (dy < BAR_R);
    diag   = (adif < T_S) || (asum < T_S);
    ring   = (d2 > R_IN2) && (d2 <= R_OUT2);
    hash_v = (ax >= Q_L) && (ax < Q_R);
    hash_h = (ay >= Q_L) && (ay < Q_R);
    frame  = (ax > HT_S) || (ay > HT_S);
    tri_up = (ax <<< 1) <= (dy + H_S);
    tri_dn = (ax <<< 1) <= (H_S - dy);
  end

  always_comb begin
    hit = 1'b0;
    case (symbol_sel)
      SYM_PLUS:   hit = inbox && (vbar || hbar);
      SYM_MINUS:  hit = inbox && hbar;
      SYM_CROSS:  hit = inbox && diag;
      SYM_CIRCLE: hit = ring;
      SYM_HASH:   hit = inbox && (hash_v || hash_h);
      SYM_SQUARE: hit = inbox && frame;
      SYM_TRI_UP: hit = inbox && tri_up;
      SYM_TRI_DN: hit = inbox && tri_dn;
      default:    hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/card_flip_renderer.sv
// One memory-game card: flip/match state machine advanced on frame_tick, plus
// combinational card, symbol and matched-border coverage for the current pixel.
module card_flip_renderer
  import card_pkg::*;
#(
  parameter int unsigned CARD_W      = DEF_CARD_W,
  parameter int unsigned CARD_H      = DEF_CARD_H,
  parameter int unsigned SYM_SIZE    = DEF_SYM_SIZE,
  parameter int unsigned SYM_T       = DEF_SYM_T,
  parameter int unsigned FLIP_FRAMES = DEF_FLIP_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] left,
  input  logic [9:0] top,
  input  logic [2:0] symbol_sel,
  input  logic       frame_tick,
  input  logic       flip_req,
  input  logic       match_set,
  output logic       incard,
  output logic       insymbol,
  output logic       inborder,
  output logic       face_up,
  output logic       busy,
  output logic       flip_done
);

  localparam int unsigned HALF = CARD_W / 2;
  localparam int unsigned STEP = HALF / FLIP_FRAMES;
  localparam int unsigned KW   = $clog2(FLIP_FRAMES + 1);
  localparam logic [KW-1:0] K_LAST = KW'(FLIP_FRAMES);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  if (((CARD_W % 2) != 0) || ((HALF % FLIP_FRAMES) != 0)) begin : g_bad_params
    $error("card_flip_renderer: CARD_W must be even and CARD_W/2 divisible by FLIP_FRAMES");
  end

  card_state_t   state, state_n;
  logic          face, face_n;
  logic          pending, pending_n;
  logic          match_pend, match_pend_n;
  logic [KW-1:0] k, k_n;
  logic          flip_done_n, busy_n;
  logic          idle_free, accept_match, accept_flip;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      face       <= 1'b0;
      pending    <= 1'b0;
      match_pend <= 1'b0;
      k          <= '0;
      flip_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      face       <= face_n;
      pending    <= pending_n;
      match_pend <= match_pend_n;
      k          <= k_n;
      flip_done  <= flip_done_n;
      busy       <= busy_n;
    end
  end

  // Requests are latched any cycle; geometry only moves on frame_tick.
  always_comb begin
    state_n      = state;
    face_n       = face;
    pending_n    = pending;
    match_pend_n = match_pend;
    k_n          = k;
    flip_done_n  = 1'b0;

    idle_free    = (state == ST_IDLE) && !pending && !match_pend;
    accept_match = match_set && idle_free && face;
    accept_flip  = flip_req && idle_free && !accept_match;

    if (frame_tick) begin
      case (state)
        ST_IDLE: begin
          if (match_pend) begin
            state_n      = ST_MATCHED;
            match_pend_n = 1'b0;
          end else if (pending) begin
            state_n   = ST_SHRINK;
            k_n       = K_ONE;
            pending_n = 1'b0;
          end
        end
        ST_SHRINK: begin
          if (k < K_LAST) begin
            k_n = k + K_ONE;
          end else begin
            face_n  = ~face;
            state_n = ST_EXPAND;
            k_n     = K_LAST - K_ONE;
          end
        end
        ST_EXPAND: begin
          if (k <= K_ONE) begin
            k_n         = '0;
            state_n     = ST_IDLE;
            flip_done_n = 1'b1;
          end else begin
            k_n = k - K_ONE;
          end
        end
        default: ;
      endcase
    end

    if (accept_match) match_pend_n = 1'b1;
    if (accept_flip)  pending_n    = 1'b1;

    busy_n = pending_n || (state_n == ST_SHRINK) || (state_n == ST_EXPAND);
  end

  assign face_up = face;

  logic [9:0]  hw, cx, cy, x_lo;
  logic [10:0] x_hi, y_hi;
  logic        sym_hit, face_shown, near_edge;

  card_symbol_gen #(
    .SYM_SIZE (SYM_SIZE),
    .SYM_T    (SYM_T)
  ) u_sym (
    .x          (x),
    .y          (y),
    .cx         (cx),
    .cy         (cy),
    .symbol_sel (symbol_sel),
    .hit        (sym_hit)
  );

  // Narrowed card rectangle about the fixed vertical centre line.
  always_comb begin
    hw   = 10'(HALF) - 10'(k) * 10'(STEP);
    cx   = left + 10'(HALF);
    cy   = top + 10'(CARD_H / 2);
    x_lo = cx - hw;
    x_hi = {1'b0, cx} + {1'b0, hw};
    y_hi = {1'b0, top} + 11'(CARD_H);

    incard = (hw != 10'd0) && (x >= x_lo) && ({1'b0, x} < x_hi)
             && (y >= top) && ({1'b0, y} < y_hi);

    face_shown = (state == ST_IDLE) || (state == ST_MATCHED);
    insymbol   = incard && face && face_shown && sym_hit;

    near_edge = (x < x_lo + 10'(SYM_T)) || ({1'b0, x} >= x_hi - 11'(SYM_T))
                || (y < top + 10'(SYM_T)) || ({1'b0, y} >= y_hi - 11'(SYM_T));
    inborder  = (state == ST_MATCHED) && incard && near_edge;
  end

endmodule

// File: tb/tb_card_flip_renderer.sv
// Randomised self-checking bench for card_flip_renderer against a frame-count
// reference model, with directed flip, match, symbol and reset scenarios.
module tb_card_flip_renderer;
  import card_pkg::*;

  localparam int W = 50, H = 70, SS = 30, ST = 4, F = 5;
  localparam int HALF = W / 2, STEP = HALF / F;
  localparam int L = 100, T0 = 80, CX = L + HALF, CY = T0 + H / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y, left, top;
  logic [2:0] symbol_sel;
  logic       frame_tick, flip_req, match_set;
  logic       incard, insymbol, inborder, face_up, busy, flip_done;

  card_flip_renderer dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .left       (left),
    .top        (top),
    .symbol_sel (symbol_sel),
    .frame_tick (frame_tick),
    .flip_req   (flip_req),
    .match_set  (match_set),
    .incard     (incard),
    .insymbol   (insymbol),
    .inborder   (inborder),
    .face_up    (face_up),
    .busy       (busy),
    .flip_done  (flip_done)
  );

  always #50 clk = ~clk;

  int n_total = 0, n_bad = 0, done_cnt = 0;

  // Model: m_anim counts frame ticks into the animation (0 = not animating).
  int m_anim;
  bit m_face, m_pending, m_mpend, m_matched, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int m_hw();
    if (m_anim == 0) return HALF;
    if (m_anim <= F) return HALF - m_anim * STEP;
    return HALF - (2 * F - m_anim) * STEP;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit m_sym(input int dx, input int dy, input int sel);
    int hh = SS / 2, q = SS / 4, tl = ST / 2;
    int ax = iabs(dx), ay = iabs(dy), d2 = dx * dx + dy * dy;
    bit inbox = (ax <= hh) && (ay <= hh);
    bit vb = (dx >= -tl) && (dx < ST - tl);
    bit hb = (dy >= -tl) && (dy < ST - tl);
    case (sel)
      0: return inbox && (vb || hb);
      1: return inbox && hb;
      2: return inbox && (iabs(dx - dy) < ST || iabs(dx + dy) < ST);
      3: return d2 > (hh - ST) * (hh - ST) && d2 <= hh * hh;
      4: return inbox && ((ax >= q - tl && ax < q + ST - tl) || (ay >= q - tl && ay < q + ST - tl));
      5: return inbox && (ax > hh - ST || ay > hh - ST);
      6: return inbox && (2 * ax <= dy + hh);
      default: return inbox && (2 * ax <= hh - dy);
    endcase
  endfunction

  function automatic void model_edge();
    bit idle, acc_m, acc_f;
    if (rst) begin
      m_anim = 0; m_face = 0; m_pending = 0; m_mpend = 0; m_matched = 0; m_done = 0;
      return;
    end
    idle  = !m_matched && m_anim == 0;
    acc_m = match_set && idle && m_face && !m_pending && !m_mpend;
    acc_f = flip_req && !acc_m && idle && !m_pending && !m_mpend;
    m_done = 0;
    if (frame_tick && !m_matched) begin
      if (m_anim > 0) begin
        m_anim++;
        if (m_anim == F + 1) m_face = !m_face;
        if (m_anim == 2 * F) begin m_anim = 0; m_done = 1; end
      end else if (m_mpend) begin
        m_matched = 1; m_mpend = 0;
      end else if (m_pending) begin
        m_anim = 1; m_pending = 0;
      end
    end
    if (acc_m) m_mpend = 1;
    if (acc_f) m_pending = 1;
  endfunction

  task automatic probe(input int px, input int py, input string tag);
    int hw = m_hw();
    bit ic, isy, ib;
    x = 10'(px); y = 10'(py);
    #1;
    ic  = hw > 0 && px >= CX - hw && px < CX + hw && py >= T0 && py < T0 + H;
    isy = ic && m_face && m_anim == 0 && m_sym(px - CX, py - CY, int'(symbol_sel));
    ib  = ic && m_matched && (px < L + ST || px >= L + W - ST || py < T0 + ST || py >= T0 + H - ST);
    chk({tag, ".incard"}, 32'(incard), 32'(ic));
    chk({tag, ".insymbol"}, 32'(insymbol), 32'(isy));
    chk({tag, ".inborder"}, 32'(inborder), 32'(ib));
  endtask

  task automatic check_state();
    int hw = m_hw();
    chk("face_up", 32'(face_up), 32'(m_face));
    chk("busy", 32'(busy), 32'(m_pending || m_anim > 0));
    chk("flip_done", 32'(flip_done), 32'(m_done));
    probe(CX - hw, CY, "edge_l");
    probe(CX - hw - 1, CY, "edge_l1");
    probe(CX + hw - 1, CY, "edge_r");
    probe(CX + hw, CY, "edge_r1");
    probe(L - 4 + int'($urandom_range(0, W + 8)), T0 - 4 + int'($urandom_range(0, H + 8)), "rnd");
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    frame_tick = 0; flip_req = 0; match_set = 0;
    if (flip_done === 1'b1) done_cnt++;
    check_state();
  endtask

  // Fixed-constant check of the current half-width via its edge pixels.
  task automatic hw_is(input int e, input string tag);
    if (e > 0) begin
      x = 10'(CX - e);     y = 10'(CY); #1; chk({tag, ".in_l"}, 32'(incard), 32'd1);
      x = 10'(CX - e - 1); #1; chk({tag, ".out_l"}, 32'(incard), 32'd0);
      x = 10'(CX + e - 1); #1; chk({tag, ".in_r"}, 32'(incard), 32'd1);
      x = 10'(CX + e);     #1; chk({tag, ".out_r"}, 32'(incard), 32'd0);
    end else begin
      x = 10'(CX - 1); y = 10'(CY); #1; chk({tag, ".zero_l"}, 32'(incard), 32'd0);
      x = 10'(CX);     #1; chk({tag, ".zero_r"}, 32'(incard), 32'd0);
    end
  endtask

  task automatic run_random(input int n, input bit with_match);
    for (int i = 0; i < n; i++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      flip_req   = ($urandom_range(0, 5) == 0);
      match_set  = with_match && ($urandom_range(0, 15) == 0);
      symbol_sel = 3'($urandom_range(0, 7));
      cycle();
    end
  endtask

  task automatic flip_animation(input int ignore_at, input string tag);
    int hw_tab[10] = '{20, 15, 10, 5, 0, 5, 10, 15, 20, 25};
    bit face0 = m_face;
    flip_req = 1; cycle();
    chk({tag, ".busy_set"}, 32'(busy), 32'd1);
    done_cnt = 0;
    for (int t = 1; t <= 10; t++) begin
      for (int j = 0, n = int'($urandom_range(1, 3)); j < n; j++) begin
        if (t == ignore_at && j == 0) flip_req = 1;
        cycle();
      end
      frame_tick = 1; cycle();
      hw_is(hw_tab[t-1], tag);
      chk({tag, ".face"}, 32'(face_up), 32'((t >= 6) ? !face0 : face0));
      chk({tag, ".done"}, 32'(flip_done), 32'(t == 10));
    end
    chk({tag, ".done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int in_x[8]  = '{CX, CX, CX + 5, CX + 15, CX + 7, CX + 15, CX, CX + 0};
    int in_y[8]  = '{CY, CY, CY + 5, CY, CY, CY, CY - 15, CY + 15};
    int out_x[8] = '{CX + 5, CX, CX + 5, CX, CX, CX, CX + 1, CX + 1};
    int out_y[8] = '{CY + 5, CY + 5, CY, CY, CY, CY, CY - 15, CY + 15};

    rst = 1; x = 0; y = 0; left = 10'(L); top = 10'(T0); symbol_sel = 0;
    frame_tick = 0; flip_req = 0; match_set = 0;
    m_anim = 0; m_face = 0; m_pending = 0; m_mpend = 0; m_matched = 0; m_done = 0;
    cycle(); cycle();
    rst = 0; cycle();

    x = 10'(L + 25); y = 10'(T0 + 35); #1;
    chk("rst.incard", 32'(incard), 32'd1);
    chk("rst.insymbol", 32'(insymbol), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.face", 32'(face_up), 32'd0);

    flip_animation(0, "flip1");
    symbol_sel = SYM_PLUS;
    x = 10'(CX); y = 10'(CY); #1;
    chk("flip1.plus_ctr", 32'(insymbol), 32'd1);

    flip_animation(3, "flip2");

    // Reset in the middle of a shrink.
    flip_req = 1; cycle();
    for (int t = 0; t < 3; t++) begin frame_tick = 1; cycle(); end
    chk("mid.busy", 32'(busy), 32'd1);
    rst = 1; cycle(); rst = 0;
    hw_is(25, "rst_mid");
    chk("rst_mid.face", 32'(face_up), 32'd0);
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.done", 32'(flip_done), 32'd0);

    run_random(300, 1'b0);

    // Settle, then make sure the card is face-up and idle.
    for (int t = 0; t < 2 * F + 2; t++) begin frame_tick = 1; cycle(); end
    if (!m_face) begin
      flip_req = 1; cycle();
      for (int t = 0; t < 2 * F + 1; t++) begin frame_tick = 1; cycle(); end
    end
    chk("sym.face", 32'(face_up), 32'd1);

    for (int s = 0; s < 8; s++) begin
      symbol_sel = 3'(s);
      probe(in_x[s], in_y[s], "sym_in");
      chk($sformatf("sym%0d.in", s), 32'(insymbol), 32'd1);
      probe(out_x[s], out_y[s], "sym_out");
      chk($sformatf("sym%0d.out", s), 32'(insymbol), 32'd0);
      for (int r = 0; r < 6; r++)
        probe(CX - 17 + int'($urandom_range(0, 34)), CY - 17 + int'($urandom_range(0, 34)), "sym_rnd");
      cycle();
    end
    symbol_sel = SYM_CIRCLE;
    x = 10'(CX + 15); y = 10'(CY); #1;
    chk("circle.rim", 32'(insymbol), 32'd1);

    // Match and flip together: match wins.
    match_set = 1; flip_req = 1; cycle();
    chk("match.busy", 32'(busy), 32'd0);
    frame_tick = 1; cycle();
    x = 10'(L + 1); y = 10'(T0 + 1); #1;
    chk("match.border", 32'(inborder), 32'd1);
    chk("match.face", 32'(face_up), 32'd1);
    flip_req = 1; cycle();
    for (int t = 0; t < 4; t++) begin frame_tick = 1; cycle(); end
    chk("match.flip_ign", 32'(busy), 32'd0);
    chk("match.face2", 32'(face_up), 32'd1);
    hw_is(25, "match");
    run_random(100, 1'b1);

    rst = 1; cycle(); rst = 0;
    run_random(400, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
